// File: rtl/dds_sweep_if.sv
// Sweep-controller port bundle: configuration handshake, abort, and the DDS
// address-control outputs (wave_sel / wave_freq) with their status flags.
interface dds_sweep_if #(
    parameter int DWELL_W = 26
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_sel;
    logic [19:0]        cfg_f_start;
    logic [19:0]        cfg_f_stop;
    logic [19:0]        cfg_f_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               abort;
    logic [1:0]         wave_sel;
    logic [19:0]        wave_freq;
    logic               freq_upd;
    logic               settled;
    logic               busy;
    logic               done;

    modport master (
        output cfg_valid, cfg_sel, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, abort,
        input  cfg_ready, wave_sel, wave_freq, freq_upd, settled, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_f_start, cfg_f_stop, cfg_f_step, cfg_dwell, abort,
        output cfg_ready, wave_sel, wave_freq, freq_upd, settled, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS front end: steps wave_freq from start to stop,
// waiting DIV_LAT cycles then dwelling at each point. DDS_SWEEP_PINGPONG_EN: endless ping-pong.
module dds_sweep_ctrl #(
    parameter int DIV_LAT = 8,
    parameter int DWELL_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    dds_sweep_if.slave  sif
);
    localparam int LAT_W = $clog2(DIV_LAT) + 1;
    localparam int CNT_W = (DWELL_W > LAT_W) ? DWELL_W : LAT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         sel_reg, sel_next;
    logic [19:0]        start_reg, start_next;
    logic [19:0]        stop_reg, stop_next;
    logic [19:0]        step_reg, step_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic               dir_up_reg, dir_up_next;
    logic               tgt_is_stop_reg, tgt_is_stop_next;
    logic [19:0]        freq_reg, freq_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               freq_upd_reg, freq_upd_next;
    logic               settled_reg, settled_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               ready_reg, ready_next;

    logic [19:0]        cur_tgt, eff_tgt, next_pt;
    logic               eff_up, at_tgt;
    logic [20:0]        sum, diff;
    logic [CNT_W-1:0]   dwell_load;

    // A dwell of 0 behaves as 1, so the counter reloads with max(dwell,1)-1.
    assign dwell_load = (dwell_reg == '0) ? '0 : (CNT_W'(dwell_reg) - CNT_W'(1));
    assign cur_tgt    = tgt_is_stop_reg ? stop_reg : start_reg;
    assign at_tgt     = (freq_reg == cur_tgt);

    always_comb begin
        eff_tgt = cur_tgt;
        eff_up  = dir_up_reg;
`ifdef DDS_SWEEP_PINGPONG_EN
        // Reaching an endpoint turns the sweep around toward the other one.
        if (at_tgt) begin
            eff_tgt = tgt_is_stop_reg ? start_reg : stop_reg;
            eff_up  = ~dir_up_reg;
        end
`endif
        // 21-bit arithmetic so overshoot past either end clamps instead of wrapping.
        sum  = {1'b0, freq_reg} + {1'b0, step_reg};
        diff = {1'b0, freq_reg} - {1'b0, step_reg};
        if (eff_up)
            next_pt = (sum > {1'b0, eff_tgt}) ? eff_tgt : sum[19:0];
        else
            next_pt = (diff[20] || (diff[19:0] < eff_tgt)) ? eff_tgt : diff[19:0];
    end

    always_comb begin
        state_next       = state_reg;
        sel_next         = sel_reg;
        start_next       = start_reg;
        stop_next        = stop_reg;
        step_next        = step_reg;
        dwell_next       = dwell_reg;
        dir_up_next      = dir_up_reg;
        tgt_is_stop_next = tgt_is_stop_reg;
        freq_next        = freq_reg;
        cnt_next         = cnt_reg;
        freq_upd_next    = 1'b0;
        done_next        = 1'b0;
        settled_next     = settled_reg;
        busy_next        = busy_reg;
        ready_next       = ready_reg;

        case (state_reg)
            IDLE: begin
                if (sif.cfg_valid) begin
                    sel_next         = sif.cfg_sel;
                    start_next       = sif.cfg_f_start;
                    stop_next        = sif.cfg_f_stop;
                    step_next        = sif.cfg_f_step;
                    dwell_next       = sif.cfg_dwell;
                    dir_up_next      = (sif.cfg_f_start <= sif.cfg_f_stop);
                    tgt_is_stop_next = 1'b1;
                    freq_next        = sif.cfg_f_start;
                    freq_upd_next    = 1'b1;
                    busy_next        = 1'b1;
                    ready_next       = 1'b0;
                    settled_next     = 1'b0;
                    cnt_next         = CNT_W'(DIV_LAT - 1);
                    state_next       = SETTLE;
                end
            end
            SETTLE: begin
                if (sif.abort) begin
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                    settled_next = 1'b0;
                    ready_next   = 1'b1;
                end else if (cnt_reg == '0) begin
                    settled_next = 1'b1;
                    cnt_next     = dwell_load;
                    state_next   = DWELL;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DWELL: begin
                if (sif.abort) begin
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                    settled_next = 1'b0;
                    ready_next   = 1'b1;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
`ifndef DDS_SWEEP_PINGPONG_EN
                end else if (at_tgt) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    settled_next = 1'b0;
                    ready_next   = 1'b1;
`endif
                end else if (next_pt == freq_reg) begin
                    // Zero step (or degenerate ping-pong) holds the point and dwells again.
                    cnt_next = dwell_load;
                end else begin
                    freq_next        = next_pt;
                    freq_upd_next    = 1'b1;
                    settled_next     = 1'b0;
                    cnt_next         = CNT_W'(DIV_LAT - 1);
                    dir_up_next      = eff_up;
                    tgt_is_stop_next = (eff_tgt == cur_tgt) ? tgt_is_stop_reg : ~tgt_is_stop_reg;
                    state_next       = SETTLE;
                end
            end
            default: begin
                state_next   = IDLE;
                busy_next    = 1'b0;
                settled_next = 1'b0;
                ready_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            sel_reg         <= '0;
            start_reg       <= '0;
            stop_reg        <= '0;
            step_reg        <= '0;
            dwell_reg       <= '0;
            dir_up_reg      <= 1'b1;
            tgt_is_stop_reg <= 1'b1;
            freq_reg        <= '0;
            cnt_reg         <= '0;
            freq_upd_reg    <= 1'b0;
            settled_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            ready_reg       <= 1'b1;
        end else begin
            state_reg       <= state_next;
            sel_reg         <= sel_next;
            start_reg       <= start_next;
            stop_reg        <= stop_next;
            step_reg        <= step_next;
            dwell_reg       <= dwell_next;
            dir_up_reg      <= dir_up_next;
            tgt_is_stop_reg <= tgt_is_stop_next;
            freq_reg        <= freq_next;
            cnt_reg         <= cnt_next;
            freq_upd_reg    <= freq_upd_next;
            settled_reg     <= settled_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            ready_reg       <= ready_next;
        end
    end

    assign sif.cfg_ready = ready_reg;
    assign sif.wave_sel  = sel_reg;
    assign sif.wave_freq = freq_reg;
    assign sif.freq_upd  = freq_upd_reg;
    assign sif.settled   = settled_reg;
    assign sif.busy      = busy_reg;
    assign sif.done      = done_reg;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus queues expected freq_upd/done events,
// a negedge monitor pops and checks value, spacing and settled-cycle count.
module tb_dds_sweep_ctrl;
    localparam int DIV_LAT = 8;
    localparam int DWELL_W = 26;

    typedef struct {
        bit          is_done;
        logic [19:0] freq;
        logic [1:0]  sel;
        int          gap;
        int          sett;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_upd = 0;
    int   sett_cnt = 0;
    exp_t q[$];

    dds_sweep_if #(.DWELL_W(DWELL_W)) sif ();

    dds_sweep_ctrl #(.DIV_LAT(DIV_LAT), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic exp_ev(bit d, logic [19:0] f, logic [1:0] s, int g, int st);
        exp_t e;
        e.is_done = d;
        e.freq    = f;
        e.sel     = s;
        e.gap     = g;
        e.sett    = st;
        q.push_back(e);
    endtask

    // Monitor: every freq_upd or done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.freq_upd || sif.done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: got upd=%0d done=%0d freq=%0d expected none (cycle %0d)",
                             sif.freq_upd, sif.done, sif.wave_freq, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("event_is_done", 32'(sif.done), 32'(e.is_done));
                    check("wave_freq", 32'(sif.wave_freq), 32'(e.freq));
                    check("wave_sel", 32'(sif.wave_sel), 32'(e.sel));
                    check("busy_at_event", 32'(sif.busy), 32'(!e.is_done));
                    if (e.gap > 0)
                        check("event_gap", 32'(cyc - last_upd), 32'(e.gap));
                    if (e.sett >= 0)
                        check("settled_cycles", 32'(sett_cnt), 32'(e.sett));
                end
                if (sif.freq_upd) begin
                    last_upd = cyc;
                    sett_cnt = 0;
                end
            end else if (sif.settled) begin
                sett_cnt++;
            end
        end
    end

    task automatic send(logic [1:0] s, logic [19:0] fa, logic [19:0] fb, logic [19:0] st, int dw);
        int n;
        n = 0;
        @(negedge clk);
        while (!sif.cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sif.cfg_ready) check("cfg_ready_timeout", 32'(sif.cfg_ready), 32'd1);
        sif.cfg_sel     = s;
        sif.cfg_f_start = fa;
        sif.cfg_f_stop  = fb;
        sif.cfg_f_step  = st;
        sif.cfg_dwell   = DWELL_W'(dw);
        sif.cfg_valid   = 1'b1;
        @(negedge clk);
        sif.cfg_valid   = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((sif.busy || q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check(name, 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_upd(logic [19:0] f);
        int n;
        n = 0;
        while (!(sif.freq_upd && sif.wave_freq == f) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wait_upd_timeout", 32'(sif.wave_freq), 32'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        sif.cfg_valid   = 1'b0;
        sif.cfg_sel     = '0;
        sif.cfg_f_start = '0;
        sif.cfg_f_stop  = '0;
        sif.cfg_f_step  = '0;
        sif.cfg_dwell   = '0;
        sif.abort       = 1'b0;
        #12;
        check("rst_wave_sel", 32'(sif.wave_sel), 32'd0);
        check("rst_wave_freq", 32'(sif.wave_freq), 32'd0);
        check("rst_freq_upd", 32'(sif.freq_upd), 32'd0);
        check("rst_settled", 32'(sif.settled), 32'd0);
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_done", 32'(sif.done), 32'd0);
        check("rst_cfg_ready", 32'(sif.cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic three-point ascending sweep, 12-cycle point period.
        exp_ev(0, 1000, 1, 0, -1);
        exp_ev(0, 1002, 1, 12, 4);
        exp_ev(0, 1004, 1, 12, 4);
        exp_ev(1, 1004, 1, 12, 4);
        send(1, 1000, 1004, 2, 4);
        wait_idle("t1_idle_timeout");

        // Clamp onto stop, including near the top of the 20-bit range.
        exp_ev(0, 100, 2, 0, -1);
        exp_ev(0, 104, 2, 11, 3);
        exp_ev(0, 105, 2, 11, 3);
        exp_ev(1, 105, 2, 11, 3);
        send(2, 100, 105, 4, 3);
        wait_idle("t2a_idle_timeout");

        exp_ev(0, 1048570, 0, 0, -1);
        exp_ev(0, 1048575, 0, 10, 2);
        exp_ev(1, 1048575, 0, 10, 2);
        send(0, 1048570, 1048575, 10, 2);
        wait_idle("t2b_idle_timeout");

        // Descending sweeps, dwell 1 and dwell 0.
        exp_ev(0, 500, 3, 0, -1);
        exp_ev(0, 495, 3, 9, 1);
        exp_ev(0, 490, 3, 9, 1);
        exp_ev(1, 490, 3, 9, 1);
        send(3, 500, 490, 5, 1);
        wait_idle("t3a_idle_timeout");

        exp_ev(0, 200, 0, 0, -1);
        exp_ev(0, 190, 0, 9, 1);
        exp_ev(1, 190, 0, 9, 1);
        send(0, 200, 190, 10, 0);
        wait_idle("t3b_idle_timeout");

        // start == stop: one point, one dwell.
        exp_ev(0, 7, 1, 0, -1);
        exp_ev(1, 7, 1, 10, 2);
        send(1, 7, 7, 3, 2);
        wait_idle("t_eq_idle_timeout");

        // Abort on the second dwell cycle of point 1002.
        exp_ev(0, 1000, 1, 0, -1);
        exp_ev(0, 1002, 1, 12, 4);
        send(1, 1000, 1004, 2, 4);
        wait_upd(1002);
        repeat (DIV_LAT + 1) @(negedge clk);
        check("abort_pre_settled", 32'(sif.settled), 32'd1);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check("abort_busy", 32'(sif.busy), 32'd0);
        check("abort_settled", 32'(sif.settled), 32'd0);
        check("abort_cfg_ready", 32'(sif.cfg_ready), 32'd1);
        check("abort_done", 32'(sif.done), 32'd0);
        check("abort_wave_freq", 32'(sif.wave_freq), 32'd1002);
        repeat (20) @(negedge clk);
        check("abort_no_events", 32'(q.size()), 32'd0);

        // Zero step holds the point; a config offered while busy is ignored.
        exp_ev(0, 10, 1, 0, -1);
        send(1, 10, 20, 0, 3);
        repeat (DIV_LAT + 2) @(negedge clk);
        check("busy_cfg_ready", 32'(sif.cfg_ready), 32'd0);
        sif.cfg_f_start = 50;
        sif.cfg_valid   = 1'b1;
        @(negedge clk);
        sif.cfg_valid   = 1'b0;
        lows = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!sif.settled) lows++;
        end
        check("step0_settled_lows", 32'(lows), 32'd0);
        check("step0_wave_freq", 32'(sif.wave_freq), 32'd10);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check("step0_abort_busy", 32'(sif.busy), 32'd0);
        check("step0_abort_ready", 32'(sif.cfg_ready), 32'd1);

        // Asynchronous reset in the middle of SETTLE.
        exp_ev(0, 1000, 1, 0, -1);
        send(1, 1000, 1004, 2, 4);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_wave_freq", 32'(sif.wave_freq), 32'd0);
        check("arst_wave_sel", 32'(sif.wave_sel), 32'd0);
        check("arst_busy", 32'(sif.busy), 32'd0);
        check("arst_settled", 32'(sif.settled), 32'd0);
        check("arst_freq_upd", 32'(sif.freq_upd), 32'd0);
        check("arst_cfg_ready", 32'(sif.cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cfg_ready", 32'(sif.cfg_ready), 32'd1);
        exp_ev(0, 100, 2, 0, -1);
        exp_ev(0, 104, 2, 11, 3);
        exp_ev(0, 105, 2, 11, 3);
        exp_ev(1, 105, 2, 11, 3);
        send(2, 100, 105, 4, 3);
        wait_idle("t6_idle_timeout");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the DDS address-control front end (wave_sel / wave_freq) through a programmed frequency sweep. It accepts one sweep configuration per valid/ready handshake and steps the output frequency from start to stop. After each frequency change it waits out the fixed latency of the frequency-word divider, then dwells for a programmed number of cycles. It also flags when the DDS output is settled and signals sweep completion.

Parameters:
DIV_LAT, 8, cycles from a wave_freq change until the DDS frequency word is valid (divider pipeline latency); must be >= 1
DWELL_W, 26, width of the dwell counter and cfg_dwell

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cfg_valid  in  1  sweep config offered
cfg_ready  out  1  controller can accept a config (high only in IDLE)
cfg_sel  in  2  waveform select for the sweep
cfg_f_start  in  20  first frequency, Hz
cfg_f_stop  in  20  final frequency, Hz
cfg_f_step  in  20  step magnitude, Hz
cfg_dwell  in  DWELL_W  settled cycles per point; 0 is treated as 1
abort  in  1  terminate an active sweep
wave_sel  out  2  to DDS address control
wave_freq  out  20  to DDS address control
freq_upd  out  1  1-cycle pulse, high in the cycle wave_freq takes a new value
settled  out  1  DDS frequency word valid for the current point
busy  out  1  sweep in progress
done  out  1  1-cycle pulse at normal sweep completion

Behaviour:
- Reset values: wave_sel=0, wave_freq=0, freq_upd=0, settled=0, busy=0, done=0, cfg_ready=1, state=IDLE. All outputs are registered.
- Accept: cfg_valid && cfg_ready at edge N.
  - All cfg_* fields are captured.
  - Direction is set: up if start <= stop, else down.
  - In cycle N+1: wave_sel=cfg_sel, wave_freq=start, freq_upd=1, busy=1, cfg_ready=0, state=SETTLE.
- cfg_* inputs are ignored outside IDLE.
- SETTLE: settled=0 for DIV_LAT cycles, counted from the freq_upd cycle. settled rises in the cycle DIV_LAT after freq_upd; state=DWELL.
- DWELL: settled=1 for exactly max(cfg_dwell,1) cycles. The cycle after the last dwell cycle resolves as follows:
  - If wave_freq == stop: state=IDLE, done=1 for 1 cycle, busy=0, settled=0, cfg_ready=1. wave_freq and wave_sel hold their last values.
  - Else if step == 0: re-dwell at the same frequency. No freq_upd, settled stays 1, and this repeats until abort.
  - Else: wave_freq = next point, freq_upd=1, settled=0, state=SETTLE.
- Point period: DIV_LAT + max(cfg_dwell,1) cycles, measured from one freq_upd to the next.
- Next point, up: compute wave_freq+step in 21 bits. If the sum exceeds stop, the next point is stop; the 20-bit wrap can never occur.
- Next point, down: compute wave_freq-step in 21 bits. If it underflows or is below stop, the next point is stop.
- start == stop: a single point with one dwell, then done (step is ignored).
- Abort:
  - Priority over all transitions in SETTLE/DWELL.
  - In the next cycle: state=IDLE, busy=0, settled=0, cfg_ready=1, no done pulse. wave_freq and wave_sel hold.
  - abort in IDLE is ignored, and cfg_valid in IDLE is accepted even if abort is high.
- New config is accepted in the same cycle done is high (state is IDLE).
- Asynchronous reset mid-sweep returns everything to reset values immediately.

Optional Feature:
Macro: DDS_SWEEP_PINGPONG_EN.
- Defined: the sweep never completes. On finishing the dwell at an endpoint, direction reverses and stepping continues toward the other endpoint using the same clamping rules. Each endpoint is dwelt once per pass, not twice. done never pulses, and busy stays 1 until abort. start == stop holds that point indefinitely.
- Undefined: single-pass behaviour as above.

Test Plan:
1. DIV_LAT=8; sel=1, start=1000, stop=1004, step=2, dwell=4 -> wave_freq 1000/1002/1004, freq_upd pulses 12 cycles apart, settled high 4 cycles per point, done 1 cycle exactly 36 cycles after the first freq_upd, wave_sel=1 throughout.
2. Clamp: start=100, stop=105, step=4 -> 100, 104, 105, then done. Also start=1048570, stop=1048575, step=10 -> 1048570, 1048575, no wrap to a small value.
3. Descending: start=500, stop=490, step=5 -> 500, 495, 490, then done. Separately, dwell=0 -> settled high 1 cycle per point.
4. Abort asserted on the 2nd dwell cycle of point 1002 (case 1) -> next cycle busy=0, settled=0, cfg_ready=1, no done, wave_freq stays 1002.
5. cfg_valid pulsed while busy -> ignored, cfg_ready=0. Config step=0, start=10, stop=20 -> wave_freq=10 with one freq_upd, settled stays 1 for over 1000 cycles until abort.
6. rst_n driven low mid-SETTLE -> all outputs return to reset values immediately, without waiting for a clock edge. After release, cfg_ready=1 and a new config is accepted normally.
